capp_cmd_master: RTL and testbench

CAPP_CMD_MASTER -- requirements
Module: capp_cmd_master

---
 rtl/capp_cmd_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_capp_cmd_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_cmd_master.sv
// capp_cmd_master: issues single-letter CAPP commands ('a'..'k') on a byte
// stream, optionally follows them with a payload word, then either collects
// a response word from the CAPP or waits out a fixed idle gap.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a command; illegal opcodes are rejected here
// SEND_CMD  | presenting the opcode letter 0x61+op on tx
// SEND_WORD | presenting the payload word, least-significant byte first
// RECV      | collecting response bytes, most-significant first, with timeout
// GAP       | idle settling time after a command that has no response
module capp_cmd_master #(
  parameter int NUM_BYTES   = 4,
  parameter int TAG_BYTES   = 2,
  parameter int GAP_CYCLES  = 32,
  parameter int RSP_TIMEOUT = 65535
) (
  input  logic                   clk_48mhz,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [8*NUM_BYTES-1:0] cmd_word,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   rsp_valid,
  output logic [8*NUM_BYTES-1:0] rsp_data,
  output logic                   done,
  output logic                   err_op,
  output logic                   err_timeout
);

  localparam int WW        = 8 * NUM_BYTES;
  localparam int MAX_BYTES = (NUM_BYTES > TAG_BYTES) ? NUM_BYTES : TAG_BYTES;
  localparam int BCW       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  // Gap and timeout counters hold "cycles remaining minus one".
  localparam int GCW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TCW       = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  localparam logic [BCW-1:0] NUM_LAST = BCW'(NUM_BYTES - 1);
  localparam logic [BCW-1:0] TAG_LAST = BCW'(TAG_BYTES - 1);
  localparam logic [GCW-1:0] GAP_LOAD = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TCW-1:0] TMR_LOAD = TCW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_CMD  = 3'd1,
    S_SEND_WORD = 3'd2,
    S_RECV      = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t          state, state_d;
  logic            run_q;
  logic [3:0]      op_q;
  logic [WW-1:0]   word_q;
  logic [BCW-1:0]  byte_cnt;
  logic [GCW-1:0]  gap_cnt;
  logic [TCW-1:0]  tmr;
  logic [WW-1:0]   rsp_sh;
  logic [WW-1:0]   sh_next;
  logic [WW-1:0]   rsp_data_q;
  logic            done_q, rsp_valid_q, err_op_q, err_to_q;

  logic            load_cmd, shift_word;
  logic            ld_cnt, dec_cnt;
  logic [BCW-1:0]  cnt_val;
  logic            ld_gap, dec_gap;
  logic            ld_tmr, dec_tmr;
  logic            clr_sh, shift_in, rsp_fire;
  logic            done_d, err_op_d, err_to_d;

  assign sh_next     = (rsp_sh << 8) | WW'(rx_data);
  assign rsp_data    = rsp_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign done        = done_q;
  assign err_op      = err_op_q;
  assign err_timeout = err_to_q;

  // State register; reset drops any command in flight straight back to IDLE.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state decode plus the handshake outputs and datapath strobes.
  always_comb begin
    state_d    = state;
    cmd_ready  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    rx_ready   = 1'b0;
    load_cmd   = 1'b0;
    shift_word = 1'b0;
    ld_cnt     = 1'b0;
    dec_cnt    = 1'b0;
    cnt_val    = '0;
    ld_gap     = 1'b0;
    dec_gap    = 1'b0;
    ld_tmr     = 1'b0;
    dec_tmr    = 1'b0;
    clr_sh     = 1'b0;
    shift_in   = 1'b0;
    rsp_fire   = 1'b0;
    done_d     = 1'b0;
    err_op_d   = 1'b0;
    err_to_d   = 1'b0;
    case (state)
      S_IDLE: begin
        // run_q keeps cmd_ready low until the first edge after reset release.
        cmd_ready = run_q;
        if (cmd_valid && run_q) begin
          load_cmd = 1'b1;
          if (cmd_op > 4'd10) err_op_d = 1'b1;
          else                state_d  = S_SEND_CMD;
        end
      end
      S_SEND_CMD: begin
        tx_valid = 1'b1;
        tx_data  = 8'h61 + {4'h0, op_q};
        if (tx_ready) begin
          case (op_q)
            4'd0, 4'd2: begin
              state_d = S_SEND_WORD;
              ld_cnt  = 1'b1;
              cnt_val = NUM_LAST;
            end
            4'd1, 4'd3, 4'd9: begin
              state_d = S_RECV;
              ld_cnt  = 1'b1;
              cnt_val = NUM_LAST;
              ld_tmr  = 1'b1;
              clr_sh  = 1'b1;
            end
            4'd5: begin
              state_d = S_RECV;
              ld_cnt  = 1'b1;
              cnt_val = TAG_LAST;
              ld_tmr  = 1'b1;
              clr_sh  = 1'b1;
            end
            default: begin
              state_d = S_GAP;
              ld_gap  = 1'b1;
            end
          endcase
        end
      end
      S_SEND_WORD: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (tx_ready) begin
          shift_word = 1'b1;
          if (byte_cnt == '0) begin
            state_d = S_GAP;
            ld_gap  = 1'b1;
          end else begin
            dec_cnt = 1'b1;
          end
        end
      end
      S_RECV: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          shift_in = 1'b1;
          if (byte_cnt == '0) begin
            rsp_fire = 1'b1;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            dec_cnt = 1'b1;
            ld_tmr  = 1'b1;
          end
        end else if (tmr == '0) begin
          err_to_d = 1'b1;
          clr_sh   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          dec_tmr = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          dec_gap = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, down-counters, response shifter and the one-cycle pulses.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      op_q        <= '0;
      word_q      <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      tmr         <= '0;
      rsp_sh      <= '0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_op_q    <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;

      if (load_cmd) begin
        op_q   <= cmd_op;
        word_q <= cmd_word;
      end else if (shift_word) begin
        word_q <= word_q >> 8;
      end

      if (ld_cnt)       byte_cnt <= cnt_val;
      else if (dec_cnt) byte_cnt <= byte_cnt - 1'b1;

      if (ld_gap)       gap_cnt <= GAP_LOAD;
      else if (dec_gap) gap_cnt <= gap_cnt - 1'b1;

      if (ld_tmr)       tmr <= TMR_LOAD;
      else if (dec_tmr) tmr <= tmr - 1'b1;

      if (clr_sh)        rsp_sh <= '0;
      else if (shift_in) rsp_sh <= sh_next;

      if (rsp_fire) rsp_data_q <= sh_next;

      done_q      <= done_d;
      rsp_valid_q <= rsp_fire;
      err_op_q    <= err_op_d;
      err_to_q    <= err_to_d;
    end
  end

endmodule

// File: tb/tb_capp_cmd_master.sv
// Randomized bench for capp_cmd_master against a transaction-level model:
// expected tx byte list, response value and event timing per command.
module tb_capp_cmd_master;

  localparam int NB  = 4;
  localparam int TB  = 2;
  localparam int GAP = 8;
  localparam int TO  = 100;

  logic          clk_48mhz;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [8*NB-1:0] cmd_word;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rsp_valid;
  logic [8*NB-1:0] rsp_data;
  logic          done;
  logic          err_op;
  logic          err_timeout;

  capp_cmd_master #(
    .NUM_BYTES(NB), .TAG_BYTES(TB), .GAP_CYCLES(GAP), .RSP_TIMEOUT(TO)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_word(cmd_word),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done),
    .err_op(err_op), .err_timeout(err_timeout)
  );

  initial clk_48mhz = 1'b0;
  always #10 clk_48mhz = ~clk_48mhz;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int done_n, rsp_n, errop_n, errto_n, txv_seen;
  int done_cyc, rsp_cyc, errop_cyc, errto_cyc;
  int last_tx_cyc, last_rx_cyc, accept_cyc;
  logic [31:0] rsp_seen;
  logic [7:0]  tx_got[$];
  logic [7:0]  rx_q[$];
  bit          cmd_pend;
  logic [3:0]  cmd_op_v;
  logic [31:0] cmd_word_v;
  bit          stall_on;
  int          stall_n;
  bit          prev_stalled;
  logic [7:0]  prev_data;
  logic [31:0] model_rsp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    done_n = 0; rsp_n = 0; errop_n = 0; errto_n = 0; txv_seen = 0;
    done_cyc = -1; rsp_cyc = -1; errop_cyc = -1; errto_cyc = -1;
    tx_got.delete();
  endtask

  // One clock: sample outputs at the falling edge, then drive the inputs for
  // the next rising edge and log the handshakes that edge will complete.
  task automatic tick();
    @(negedge clk_48mhz);
    cyc++;
    if (prev_stalled) begin
      check_eq("tx_hold_valid", tx_valid, 1);
      check_eq("tx_hold_data", tx_data, prev_data);
    end
    if (done)        begin done_n++;  done_cyc  = cyc; end
    if (rsp_valid)   begin rsp_n++;   rsp_cyc   = cyc; rsp_seen = rsp_data; end
    if (err_op)      begin errop_n++; errop_cyc = cyc; end
    if (err_timeout) begin errto_n++; errto_cyc = cyc; end
    if (tx_valid) txv_seen++;

    cmd_valid = cmd_pend;
    cmd_op    = cmd_op_v;
    cmd_word  = cmd_word_v;
    if (cmd_pend && cmd_ready) begin
      cmd_pend   = 1'b0;
      accept_cyc = cyc;
    end

    if (stall_on && tx_valid && tx_data == 8'h33 && stall_n < 5) begin
      tx_ready = 1'b0;
      stall_n++;
    end else begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end

    if (rx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      rx_valid = 1'b1;
      rx_data  = rx_q[0];
    end else if (rx_q.size() == 0 && !rx_ready) begin
      rx_valid = $urandom_range(0, 1) != 0;
      rx_data  = 8'($urandom);
    end else begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end

    if (tx_valid && tx_ready) begin
      tx_got.push_back(tx_data);
      last_tx_cyc = cyc;
    end
    if (rx_valid && rx_ready && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      last_rx_cyc = cyc;
    end
    prev_stalled = tx_valid && !tx_ready;
    prev_data    = tx_data;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] word,
                         input int nrx, input logic [31:0] rx_word);
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rsp;
    int          need;
    bit          got_out;
    int          ref_cyc;
    string       nm;
    nm = $sformatf("op%0d", op);
    exp_tx = {};
    if (op <= 4'd10) exp_tx.push_back(8'h61 + 8'(op));
    if (op == 4'd0 || op == 4'd2)
      for (int i = 0; i < NB; i++) exp_tx.push_back(word[8*i +: 8]);
    need = (op == 4'd1 || op == 4'd3 || op == 4'd9) ? NB : (op == 4'd5) ? TB : 0;

    rx_q.delete();
    for (int i = 0; i < nrx; i++) rx_q.push_back(rx_word[8*(nrx-1-i) +: 8]);
    exp_rsp = (nrx >= 4) ? rx_word : (rx_word & ((32'd1 << (8*nrx)) - 32'd1));

    clear_obs();
    cmd_op_v   = op;
    cmd_word_v = word;
    cmd_pend   = 1'b1;
    got_out    = 1'b0;
    for (int t = 0; t < 1500 && !got_out; t++) begin
      tick();
      got_out = (done_n + errop_n + errto_n) > 0;
    end
    check_eq({nm, "_outcome_seen"}, got_out, 1);
    check_eq({nm, "_cmd_ready_after"}, cmd_ready, 1);
    repeat (3) tick();

    check_eq({nm, "_tx_count"}, tx_got.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      check_eq($sformatf("%s_tx_byte%0d", nm, i),
               (i < tx_got.size()) ? {1'b0, tx_got[i]} : 9'h100, {1'b0, exp_tx[i]});

    if (op > 4'd10) begin
      check_eq({nm, "_err_op_n"}, errop_n, 1);
      check_eq({nm, "_err_op_time"}, errop_cyc, accept_cyc + 1);
      check_eq({nm, "_no_tx_valid"}, txv_seen, 0);
      check_eq({nm, "_no_done"}, done_n, 0);
    end else if (need > 0 && nrx < need) begin
      ref_cyc = (nrx > 0) ? last_rx_cyc : last_tx_cyc;
      check_eq({nm, "_timeout_n"}, errto_n, 1);
      check_eq({nm, "_timeout_time"}, errto_cyc, ref_cyc + 1 + TO);
      check_eq({nm, "_to_no_done"}, done_n, 0);
      check_eq({nm, "_to_no_rsp"}, rsp_n, 0);
      check_eq({nm, "_to_rsp_hold"}, rsp_data, model_rsp);
    end else if (need > 0) begin
      check_eq({nm, "_rsp_n"}, rsp_n, 1);
      check_eq({nm, "_done_n"}, done_n, 1);
      check_eq({nm, "_rsp_val"}, rsp_seen, exp_rsp);
      check_eq({nm, "_rsp_done_same"}, rsp_cyc, done_cyc);
      check_eq({nm, "_rsp_time"}, done_cyc, last_rx_cyc + 1);
      check_eq({nm, "_rsp_hold"}, rsp_data, exp_rsp);
      check_eq({nm, "_rsp_no_err"}, errto_n, 0);
      model_rsp = exp_rsp;
    end else begin
      check_eq({nm, "_done_n"}, done_n, 1);
      check_eq({nm, "_gap_no_rsp"}, rsp_n, 0);
      check_eq({nm, "_gap_time"}, done_cyc, last_tx_cyc + 1 + ((GAP > 0) ? GAP : 1));
      check_eq({nm, "_gap_rsp_hold"}, rsp_data, model_rsp);
    end
  endtask

  initial begin
    logic [3:0] op;
    int need, nrx;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_word = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    cmd_pend = 1'b0; cmd_op_v = '0; cmd_word_v = '0;
    stall_on = 1'b0; stall_n = 0; prev_stalled = 1'b0; prev_data = '0;
    model_rsp = '0; rsp_seen = '0; accept_cyc = 0; last_tx_cyc = 0; last_rx_cyc = 0;
    clear_obs();

    #5;
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_rx_ready", rx_ready, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_pulses", {rsp_valid, done, err_op, err_timeout}, 0);
    repeat (2) @(negedge clk_48mhz);
    reset_n = 1'b1;
    #1 check_eq("rel_cmd_ready_pre_edge", cmd_ready, 0);
    tick();
    check_eq("rel_cmd_ready", cmd_ready, 1);

    run_cmd(4'd0, 32'h11223344, 0, 0);
    run_cmd(4'd3, $urandom, 4, 32'hDEADBEEF);
    run_cmd(4'd5, $urandom, 2, 32'h00001234);
    stall_on = 1'b1; stall_n = 0;
    run_cmd(4'd0, 32'h11223344, 0, 0);
    stall_on = 1'b0;
    check_eq("stall_cycles", stall_n, 5);
    run_cmd(4'd12, $urandom, 0, 0);
    run_cmd(4'd9, $urandom, 2, 32'h0000A5C3);

    for (int k = 0; k < 30; k++) begin
      op = 4'($urandom_range(0, 15));
      need = (op == 4'd1 || op == 4'd3 || op == 4'd9) ? NB : (op == 4'd5) ? TB : 0;
      nrx = 0;
      if (need > 0) nrx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, need - 1) : need;
      run_cmd(op, $urandom, nrx, $urandom);
      repeat ($urandom_range(0, 3)) tick();
    end

    clear_obs();
    cmd_op_v = 4'd0; cmd_word_v = $urandom; cmd_pend = 1'b1;
    for (int t = 0; t < 200 && tx_got.size() < 2; t++) tick();
    check_eq("rst_mid_in_word", tx_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_tx_valid", tx_valid, 0);
    check_eq("rst_mid_cmd_ready", cmd_ready, 0);
    check_eq("rst_mid_rx_ready", rx_ready, 0);
    check_eq("rst_mid_rsp_data", rsp_data, 0);
    cmd_pend = 1'b0; rx_q.delete(); model_rsp = '0;
    @(posedge clk_48mhz); #1;
    check_eq("rst_hold_cmd_ready", cmd_ready, 0);
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    prev_stalled = 1'b0;
    clear_obs();
    tick();
    check_eq("rst2_cmd_ready", cmd_ready, 1);
    repeat (5) tick();
    check_eq("rst2_no_tx_valid", txv_seen, 0);
    check_eq("rst2_no_tx_bytes", tx_got.size(), 0);
    run_cmd(4'd1, $urandom, NB, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
